// File: rtl/inst_fetch.sv
// Prefetching instruction fetch unit: in-order memory requests, prefetch FIFO, redirect flush.
// Define IFETCH_MISALIGN_CHECK_EN to fault on misaligned redirect targets instead of aligning them.
module inst_fetch #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             fetch_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = CW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [WIDTH-1:0] r_fifo_data [DEPTH];
  logic [WIDTH-1:0] r_fifo_pc   [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count, r_outstanding, r_discard;
  logic [TW-1:0]    r_total;
  logic [WIDTH-1:0] r_fetch_pc, r_resp_pc;
  logic             r_fault;

  logic             w_accept, w_stale, w_resp, w_push, w_pop, w_misalign;
  logic [CW:0]      w_occupancy;
  logic [WIDTH-1:0] w_target;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign w_misalign = (redirect_pc[1:0] != 2'b00);
  assign w_target   = redirect_pc;
`else
  assign w_misalign = 1'b0;
  assign w_target   = {redirect_pc[WIDTH-1:2], 2'b00};
`endif

  assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding};
  assign mem_req     = !rst && !redirect && !r_fault && (w_occupancy < LIMIT);
  assign mem_addr    = r_fetch_pc;
  assign w_accept    = mem_req && mem_gnt;

  // Responses to requests issued before the last reset arrive first and are never kept.
  assign w_stale = mem_rvalid && (r_total > {1'b0, r_outstanding});
  assign w_resp  = mem_rvalid && !w_stale;
  assign w_push  = w_resp && (r_discard == '0) && !redirect;
  assign w_pop   = inst_valid && inst_ready && !redirect;

  assign inst_valid  = (r_count != '0);
  assign inst        = inst_valid ? r_fifo_data[r_rptr] : '0;
  assign inst_pc     = inst_valid ? r_fifo_pc[r_rptr]   : '0;
  assign fetch_fault = r_fault;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= mem_rdata;
      r_fifo_pc[r_wptr]   <= r_resp_pc;
    end
  end

  // Total in-flight count deliberately survives reset so pre-reset responses can be recognised.
  always_ff @(posedge clk) begin
    if (w_accept && !mem_rvalid) begin
      r_total <= r_total + TW'(1);
    end else if (!w_accept && mem_rvalid && (r_total != '0)) begin
      r_total <= r_total - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_fault       <= 1'b0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      case ({w_accept, w_resp})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: ;
      endcase
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + WIDTH'(4);
      end
      if (redirect) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_fault    <= w_misalign;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_discard  <= r_outstanding - CW'(w_resp);
      end else begin
        if (w_resp && (r_discard != '0)) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_push) begin
          r_wptr    <= r_wptr + AW'(1);
          r_resp_pc <= r_resp_pc + WIDTH'(4);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed scenarios followed by randomized traffic against a program-order model.
// Honours IFETCH_MISALIGN_CHECK_EN to select the expected misaligned-redirect behaviour.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } expT;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } respT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        fetch_fault;

   int compared = 0;
   int mismatched = 0;

   expT         expQ[$];
   logic [31:0] expNext;
   logic [31:0] expReqAddr = RESET_PC;
   logic        faulted = 1'b0;

   respT        respQ[$];
   int          cycleCount = 0;
   int          grantCount = 0;
   int          gntMode = 1;
   int          lat = 1;
   logic        respRandom = 1'b0;
   logic        prevStall = 1'b0;
   logic [31:0] prevAddr = 32'h0;

   inst_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_fault (fetch_fault)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Contents of instruction memory: a fixed scramble of the word address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Every comparison funnels through here so the counters stay consistent.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Program order restarts at a new pc: the cpu must next see pc, pc+4, pc+8 ...
   task automatic reloadStream(input logic [31:0] base);
      expQ.delete();
      expNext = base;
   endtask

   // Drives one cycle of cpu-side stimulus at the falling edge and updates the reference model.
   task automatic applyStimulus(input logic rstV, input logic readyV, input logic redirV, input logic [31:0] pcV);
      @(negedge clk);
      rst         = rstV;
      inst_ready  = readyV;
      redirect    = redirV;
      redirect_pc = pcV;
      if (rstV) begin
         faulted    = 1'b0;
         grantCount = 0;
         reloadStream(RESET_PC);
         expReqAddr = RESET_PC;
      end else if (redirV) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
         if (pcV[1:0] != 2'b00) begin
            faulted = 1'b1;
            expQ.delete();
         end else begin
            faulted = 1'b0;
            reloadStream(pcV);
            expReqAddr = pcV;
         end
`else
         reloadStream({pcV[31:2], 2'b00});
         expReqAddr = {pcV[31:2], 2'b00};
`endif
      end
      while (!faulted && expQ.size() < 32) begin
         expQ.push_back('{pc: expNext, data: memWord(expNext)});
         expNext = expNext + 32'd4;
      end
      #3;
   endtask

   // Memory model: grants per gntMode, answers in order after at least lat cycles, never stalls responses.
   always begin
      @(negedge clk);
      cycleCount++;
      case (gntMode)
         0:       mem_gnt = ($urandom_range(0, 3) != 0);
         1:       mem_gnt = 1'b1;
         default: mem_gnt = 1'b0;
      endcase
      if (respQ.size() > 0 && respQ[0].due <= cycleCount && (!respRandom || $urandom_range(0, 3) != 0)) begin
         mem_rvalid = 1'b1;
         mem_rdata  = memWord(respQ[0].addr);
         void'(respQ.pop_front());
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = 32'hDEAD_BEEF;
      end
      #1;
      if (prevStall && mem_req) checkOutput("addr_hold", mem_addr, prevAddr);
      prevStall = mem_req && !mem_gnt;
      prevAddr  = mem_addr;
      if (mem_req && mem_gnt) begin
         checkOutput("req_addr", mem_addr, expReqAddr);
         expReqAddr = expReqAddr + 32'd4;
         grantCount++;
         respQ.push_back('{addr: mem_addr, due: cycleCount + lat});
      end
   end

   // Monitor: every instruction the cpu consumes must be the next one in program order.
   always begin
      @(negedge clk);
      #2;
      if (!rst && !redirect && inst_valid && inst_ready) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL sb_unexpected: got pc %h, expected no instruction", inst_pc);
         end else begin
            expT e;
            e = expQ.pop_front();
            checkOutput("sb_pc", inst_pc, e.pc);
            checkOutput("sb_inst", inst, e.data);
         end
      end
   end

   // Lets in-flight requests complete and the FIFO empty with grants withheld.
   task automatic drain();
      lat = 1;
      respRandom = 1'b0;
      gntMode = 2;
      repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      gntMode = 1;
   endtask

   initial begin
      int waitCycles;
      reloadStream(RESET_PC);

      // Reset values.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("rst_mem_req", mem_req, 1'b0);
      checkOutput("rst_inst_valid", inst_valid, 1'b0);
      checkOutput("rst_fault", fetch_fault, 1'b0);
      checkOutput("rst_inst", inst, 32'h0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);

      // Reset release with always-grant, 1-cycle memory, cpu stalled.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("first_req", mem_req, 1'b1);
      checkOutput("first_addr", mem_addr, RESET_PC);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("c1_valid", inst_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("c2_valid", inst_valid, 1'b1);
      checkOutput("c2_pc", inst_pc, RESET_PC);
      checkOutput("c2_inst", inst, memWord(RESET_PC));
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
         checkOutput("full_no_req", mem_req, 1'b0);
         checkOutput("full_grants", grantCount, 32'd4);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("restart_req", mem_req, 1'b1);
      checkOutput("restart_addr", mem_addr, RESET_PC + 32'h10);

      // Redirect to 0x100 with two requests outstanding.
      drain();
      lat = 4;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      gntMode = 2;
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
      gntMode = 1;
      lat = 1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("redir_empty", inst_valid, 1'b0);
      checkOutput("redir_req_addr", mem_addr, 32'h100);
      waitCycles = 0;
      while (!inst_valid && waitCycles < 20) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
         waitCycles++;
      end
      checkOutput("redir_valid", inst_valid, 1'b1);
      checkOutput("redir_pc", inst_pc, 32'h100);
      checkOutput("redir_inst", inst, memWord(32'h100));

      // Redirect coinciding with a pop and a response.
      drain();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h300);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h400);
      checkOutput("coinc_valid", inst_valid, 1'b1);
      checkOutput("coinc_rvalid", mem_rvalid, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("coinc_flushed", inst_valid, 1'b0);
      checkOutput("coinc_req_addr", mem_addr, 32'h400);

      // Misaligned redirect target.
      drain();
`ifdef IFETCH_MISALIGN_CHECK_EN
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
         checkOutput("fault_flag", fetch_fault, 1'b1);
         checkOutput("fault_no_req", mem_req, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("fault_cleared", fetch_fault, 1'b0);
      checkOutput("fault_req", mem_req, 1'b1);
      checkOutput("fault_req_addr", mem_addr, 32'h200);
`else
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("align_fault", fetch_fault, 1'b0);
      checkOutput("align_req", mem_req, 1'b1);
      checkOutput("align_req_addr", mem_addr, 32'h100);
`endif

      // Fetch address wraps at the top of the address space.
      drain();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("wrap_top", mem_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("wrap_zero", mem_addr, 32'h0000_0000);

      // Randomized traffic: grants, latencies, stalls, redirects and mid-operation resets.
      gntMode = 0;
      respRandom = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         logic        rstV;
         logic        redV;
         logic [31:0] target;
         lat    = $urandom_range(1, 4);
         rstV   = ($urandom_range(0, 299) == 0);
         redV   = !rstV && ($urandom_range(0, 24) == 0);
         target = $urandom();
`ifdef IFETCH_MISALIGN_CHECK_EN
         target[1:0] = 2'b00;
`endif
         applyStimulus(rstV, ($urandom_range(0, 9) < 7), redV, target);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the instruction and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, the prefetch FIFO entry count; it is a power of two and at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port mem_req, output, 1 bit: instruction memory request valid.
REQ-007 SHALL have port mem_addr, output, WIDTH bits: request word address.
REQ-008 SHALL have port mem_gnt, input, 1 bit: memory accepts the request when mem_req and mem_gnt are both high.
REQ-009 SHALL have ports mem_rvalid (input, 1 bit) and mem_rdata (input, WIDTH bits): the in-order response, which is never back-pressured.
REQ-010 SHALL have ports inst (output, WIDTH bits), inst_pc (output, WIDTH bits) and inst_valid (output, 1 bit): the instruction presented to the cpu.
REQ-011 SHALL have port inst_ready, input, 1 bit: the cpu consumes the FIFO head when inst_valid and inst_ready are both high.
REQ-012 SHALL have ports redirect (input, 1 bit) and redirect_pc (input, WIDTH bits): the branch/jump target from the cpu.
REQ-013 SHALL have port fetch_fault, output, 1 bit: misaligned-redirect fault flag (see Configuration).

Function
REQ-014 SHALL keep fetch_pc; each accepted request uses mem_addr = fetch_pc, then fetch_pc += 4 and wraps modulo 2^WIDTH.
REQ-015 SHALL assert mem_req only when (FIFO count + outstanding) < DEPTH, redirect is low, rst is low and fetch_fault is low.
REQ-016 SHALL hold mem_addr stable while mem_req is high and mem_gnt is low.
REQ-017 SHALL write each non-discarded response into the FIFO with mem_rdata and its request pc; it is visible on inst/inst_pc the cycle after mem_rvalid.
REQ-018 SHALL drive inst_valid = FIFO not empty, with inst/inst_pc taken from the FIFO head; there is no combinational path from mem_rdata to inst.
REQ-019 SHALL support a FIFO push and pop in the same cycle, leaving the count unchanged, including when the FIFO is full.
REQ-020 SHALL, on redirect high, clear the FIFO, ignore any same-cycle pop, drop any same-cycle response, set fetch_pc = redirect_pc and set discard = outstanding after the edge.
REQ-021 SHALL drop every response while discard > 0, decrementing both discard and outstanding.
REQ-022 SHALL re-assert mem_req with the new target the cycle after redirect deasserts.
REQ-023 SHALL let the latest redirect win when redirects occur on back-to-back cycles, with the discard count accumulated correctly.
REQ-024 SHALL keep outstanding within 0..DEPTH and the FIFO count within 0..DEPTH; overflow and underflow are impossible by construction.

Reset
REQ-025 SHALL, while rst is high, force mem_req=0, inst_valid=0, fetch_fault=0, inst=0, inst_pc=0, FIFO empty, outstanding=0, discard=0 and fetch_pc=RESET_PC.
REQ-026 SHALL drop any response arriving during or after a mid-operation reset unless it answers a post-reset request, so discard continues across reset for requests in flight.
REQ-027 SHALL assert the first mem_req, addr RESET_PC, in the first cycle after rst falls.

Configuration
REQ-028 SHALL, with IFETCH_MISALIGN_CHECK_EN defined, treat a redirect with redirect_pc[1:0] != 0 as a fault: set fetch_fault=1, flush as in REQ-020, and issue no requests until the next aligned redirect clears fetch_fault.
REQ-029 SHALL, without IFETCH_MISALIGN_CHECK_EN, force redirect_pc[1:0] to 0 and tie fetch_fault to 0.

Verification
REQ-030 SHALL cover reset release with mem_gnt=1 and 1-cycle responses: mem_addr sequence 0,4,8,C; the first inst_valid appears 2 cycles after the first grant, with inst_pc=0.
REQ-031 SHALL cover inst_ready=0 with memory always granting: exactly DEPTH=4 requests are issued, then mem_req=0; one pop restarts requests at addr 0x10.
REQ-032 SHALL cover redirect to 0x100 with 2 responses outstanding: both late responses are dropped, the FIFO is empty, the next inst_pc=0x100 and the next data=0x100's word.
REQ-033 SHALL cover redirect in the same cycle as a pop and an rvalid: no instruction is delivered, the pop has no effect and the response is dropped.
REQ-034 SHALL cover, with the macro defined, redirect_pc=0x102: fetch_fault=1 and mem_req=0 until redirect_pc=0x200; without the macro, the first fetch is from 0x100.
REQ-035 SHALL cover fetch_pc=0xFFFF_FFFC: the next request address wraps to 0x0000_0000.
